// File: rtl/i2c_byte_sequencer_block.sv
// Byte-level I2C master sequencer: START/repeated START, one 8-bit write or read,
// the ACK bit and optional STOP, timed off the SCL generator's edge counter.
//   state  | meaning
//   IDLE   | generator held in reset, bus released, waiting for a command
//   START  | SDA low while SCL high; first bit driven at the next chg
//   BIT    | shifting the 8 data bits
//   ACK    | 9th bit; response issued at its closing chg
//   STOP   | SDA released while SCL is high, then back to IDLE
//   HOLD   | generator running, bus SCL held low until the next command
//   RSTART | SDA released in the low phase, pulled low in the high phase
module i2c_byte_sequencer_block (
    input  logic       i2c_core_clock_i,
    input  logic       reset_bit_i,
    input  logic [7:0] prescaler_i,
    input  logic [7:0] counter_detect_edge_i,
    input  logic       scl_i,
    output logic       clk_gen_rst_n_o,
    output logic       scl_oe_o,
    input  logic       sda_i,
    output logic       sda_oe_o,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [2:0] cmd_i,
    input  logic [7:0] data_i,
    input  logic       ack_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_data_o,
    output logic       rsp_nack_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, HOLD, RSTART} state_t;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       start_q, stop_q, read_q, ack_q, nack_q, pend_q;
    logic       chg, smp, accept;

    // smp also requires the generator SCL high, so a counter glitch cannot sample in the low phase
    assign chg    = clk_gen_rst_n_o && (counter_detect_edge_i == {1'b0, prescaler_i[7:1]});
    assign smp    = clk_gen_rst_n_o && scl_i &&
                    (counter_detect_edge_i == (prescaler_i + {1'b0, prescaler_i[7:1]}));
    assign accept = cmd_valid_i && cmd_ready_o;

    always_ff @(posedge i2c_core_clock_i) begin
        if (reset_bit_i) begin
            state           <= IDLE;
            bit_cnt         <= 3'd0;
            shreg           <= 8'd0;
            start_q         <= 1'b0;
            stop_q          <= 1'b0;
            read_q          <= 1'b0;
            ack_q           <= 1'b0;
            nack_q          <= 1'b0;
            pend_q          <= 1'b0;
            sda_oe_o        <= 1'b0;
            scl_oe_o        <= 1'b0;
            clk_gen_rst_n_o <= 1'b0;
            cmd_ready_o     <= 1'b0;
            rsp_valid_o     <= 1'b0;
            rsp_data_o      <= 8'd0;
            rsp_nack_o      <= 1'b0;
            busy_o          <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready_o <= 1'b1;
                    if (accept) begin
                        {start_q, stop_q, read_q} <= cmd_i;
                        shreg <= data_i;
                        ack_q <= ack_i;
                        if (cmd_i[2]) begin
                            state           <= START;
                            sda_oe_o        <= 1'b1;
                            clk_gen_rst_n_o <= 1'b1;
                            busy_o          <= 1'b1;
                            cmd_ready_o     <= 1'b0;
                        end else begin
                            rsp_valid_o <= 1'b1;
                            rsp_nack_o  <= 1'b1;
                            rsp_data_o  <= 8'd0;
                        end
                    end
                end
                START: begin
                    if (chg) begin
                        sda_oe_o <= ~read_q & ~shreg[7];
                        bit_cnt  <= 3'd7;
                        state    <= BIT;
                    end
                end
                BIT: begin
                    if (smp && read_q)
                        shreg <= {shreg[6:0], sda_i};
                    if (chg) begin
                        if (bit_cnt != 3'd0) begin
                            bit_cnt  <= bit_cnt - 3'd1;
                            sda_oe_o <= ~read_q & ~shreg[bit_cnt - 3'd1];
                        end else begin
                            sda_oe_o <= read_q & ack_q;
                            state    <= ACK;
                        end
                    end
                end
                ACK: begin
                    if (smp)
                        nack_q <= read_q ? ~ack_q : sda_i;
                    if (chg) begin
                        rsp_valid_o <= 1'b1;
                        rsp_data_o  <= shreg;
                        rsp_nack_o  <= nack_q;
                        if (stop_q) begin
                            sda_oe_o <= 1'b1;
                            state    <= STOP;
                        end else begin
                            scl_oe_o    <= 1'b1;
                            cmd_ready_o <= 1'b1;
                            pend_q      <= 1'b0;
                            state       <= HOLD;
                        end
                    end
                end
                STOP: begin
                    if (smp) begin
                        sda_oe_o        <= 1'b0;
                        clk_gen_rst_n_o <= 1'b0;
                        busy_o          <= 1'b0;
                        cmd_ready_o     <= 1'b1;
                        state           <= IDLE;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        {start_q, stop_q, read_q} <= cmd_i;
                        shreg       <= data_i;
                        ack_q       <= ack_i;
                        pend_q      <= 1'b1;
                        cmd_ready_o <= 1'b0;
                    end
                    // a command taken on a chg cycle itself waits for the following chg
                    if (chg && pend_q) begin
                        pend_q   <= 1'b0;
                        scl_oe_o <= 1'b0;
                        if (start_q) begin
                            sda_oe_o <= 1'b0;
                            state    <= RSTART;
                        end else begin
                            sda_oe_o <= ~read_q & ~shreg[7];
                            bit_cnt  <= 3'd7;
                            state    <= BIT;
                        end
                    end
                end
                RSTART: begin
                    if (smp) begin
                        sda_oe_o <= 1'b1;
                        state    <= START;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
